hamming_secded_tx: RTL and testbench

Transmit-side SECDED channel encoder for the serial link: accepts data bytes over a valid/ready handshake, encodes each nibble into an 8-bit Hamming(7,4)-plus-overall-parity symbol, and shifts the symbols out one bit at a time at a programmable bit period. It is the counterpart of `hamming_decoder` on the receive side. Its codeword bit layout and parity bit match that decoder's `in[6:0]`/`in_parity` inputs exactly.

---
 rtl/hamming_secded_tx.sv | 112 +++++++++++
 tb/tb_hamming_secded_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_secded_tx.sv
// SECDED serial transmitter: each byte becomes two Hamming(7,4)+parity symbols,
// low nibble first, shifted out MSB first with every bit held CLKS_PER_BIT cycles.
module hamming_secded_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       tx_done
);

    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PER_W-1:0] per_cnt;
    logic [2:0]       bit_cnt;
    logic [15:0]      shift_q;
    logic [15:0]      enc_word;
    logic             bit_end;
    logic             sym_end;
    logic             accept;

    // Symbol layout is {code[6:0], parity}, code = {d3, d2, d1, p4, d0, p2, p1}.
    function automatic logic [7:0] encode_nibble(input logic [3:0] d);
        logic       p1;
        logic       p2;
        logic       p4;
        logic [6:0] code;
        p1   = d[0] ^ d[1] ^ d[3];
        p2   = d[0] ^ d[2] ^ d[3];
        p4   = d[1] ^ d[2] ^ d[3];
        code = {d[3], d[2], d[1], p4, d[0], p2, p1};
        return {code, ^code};
    endfunction

    assign enc_word = {encode_nibble(in_data[3:0]), encode_nibble(in_data[7:4])};
    assign bit_end  = (per_cnt == PER_LAST);
    assign sym_end  = bit_end && (bit_cnt == 3'd7);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SEND_LO;
            end
            SEND_LO: begin
                if (sym_end) state_nxt = SEND_HI;
            end
            SEND_HI: begin
                // Opening the handshake in the last cycle lets bytes stream gaplessly.
                if (sym_end) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? SEND_LO : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            per_cnt   <= '0;
            bit_cnt   <= '0;
            tx_bit    <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_active <= (state_nxt != IDLE);
            tx_done   <= (state == SEND_HI) && sym_end;
            if (accept) begin
                per_cnt <= '0;
                bit_cnt <= '0;
                tx_bit  <= enc_word[15];
            end else if (state != IDLE) begin
                if (bit_end) begin
                    per_cnt <= '0;
                    bit_cnt <= bit_cnt + 3'd1;
                    tx_bit  <= (state_nxt == IDLE) ? 1'b0 : shift_q[14];
                end else begin
                    per_cnt <= per_cnt + PER_W'(1);
                end
            end
        end
    end

    // Payload register: bit 15 is always the bit currently on the line.
    always_ff @(posedge clk) begin
        if (accept) begin
            shift_q <= enc_word;
        end else if ((state != IDLE) && bit_end) begin
            shift_q <= {shift_q[14:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_hamming_secded_tx.sv
// Bench for hamming_secded_tx: two instances (4 and 1 clocks per bit) checked every
// cycle against a positional Hamming model, plus directed streams and a decoder loopback.
module tb_hamming_secded_tx;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:0]      in_valid_v = '0;
    logic [1:0][7:0] in_data_v = '0;
    logic [1:0]      in_ready_v;
    logic [1:0]      tx_bit_v;
    logic [1:0]      tx_active_v;
    logic [1:0]      tx_done_v;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hamming_secded_tx #(.CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
        .in_ready(in_ready_v[0]), .tx_bit(tx_bit_v[0]), .tx_active(tx_active_v[0]),
        .tx_done(tx_done_v[0]));

    hamming_secded_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
        .in_ready(in_ready_v[1]), .tx_bit(tx_bit_v[1]), .tx_active(tx_active_v[1]),
        .tx_done(tx_done_v[1]));

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Symbol bit i holds Hamming position i (7..1); bit 0 is overall even parity.
    function automatic logic [7:0] model_enc(input logic [3:0] d);
        logic       b [1:7];
        logic [7:0] sym;
        int         pp;
        b[3] = d[0]; b[5] = d[1]; b[6] = d[2]; b[7] = d[3];
        for (int k = 0; k < 3; k++) begin
            pp    = 1 << k;
            b[pp] = 1'b0;
            for (int i = 1; i <= 7; i++)
                if (((i & pp) != 0) && (i != pp)) b[pp] = b[pp] ^ b[i];
        end
        sym = '0;
        for (int i = 1; i <= 7; i++) sym[i] = b[i];
        sym[0] = ^sym[7:1];
        return sym;
    endfunction

    // Returns {error_2bit, error_1bit, data[3:0]}.
    function automatic logic [5:0] model_dec(input logic [7:0] sym);
        logic [7:0] c;
        int         s;
        logic       odd;
        c   = sym;
        s   = 0;
        odd = ^sym;
        for (int i = 1; i <= 7; i++) if (sym[i]) s = s ^ i;
        if (s != 0 && odd) c[s] = ~c[s];
        return {(s != 0) && !odd, odd, c[7], c[6], c[5], c[3]};
    endfunction

    bit          busy   [2];
    int          cyc    [2];
    logic [15:0] word   [2];
    bit          done_e [2];
    logic [7:0]  sent_q [$];

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic logic exp_ready(input int i);
        return !busy[i] || (cyc[i] == 16 * cpb_of(i) - 1);
    endfunction

    function automatic logic exp_bit(input int i);
        return busy[i] ? word[i][15 - cyc[i] / cpb_of(i)] : 1'b0;
    endfunction

    // Model: a byte occupies 16*CPB cycles counted by cyc; the accept decision uses
    // the model's own readiness, never the DUT's.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                busy[i] = 1'b0; cyc[i] = 0; done_e[i] = 1'b0;
            end
            sent_q.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit acc;
                bit fin;
                acc = in_valid_v[i] && exp_ready(i);
                fin = busy[i] && (cyc[i] == 16 * cpb_of(i) - 1);
                if (busy[i]) begin
                    if (fin) busy[i] = 1'b0;
                    else     cyc[i]++;
                end
                if (acc) begin
                    busy[i] = 1'b1;
                    cyc[i]  = 0;
                    word[i] = {model_enc(in_data_v[i][3:0]), model_enc(in_data_v[i][7:4])};
                    if (i == 1) sent_q.push_back(in_data_v[i]);
                end
                done_e[i] = fin;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("in_ready",  i, in_ready_v[i],  exp_ready(i));
            chk("tx_active", i, tx_active_v[i], busy[i]);
            chk("tx_bit",    i, tx_bit_v[i],    exp_bit(i));
            chk("tx_done",   i, tx_done_v[i],   done_e[i]);
        end
    end

    task automatic check_byte(input logic [15:0] rx);
        logic [7:0] exp;
        logic [5:0] lo;
        logic [5:0] hi;
        int         pl;
        int         ph;
        if (sent_q.size() == 0) begin
            chk("rx_unexpected_byte", 1, rx, 0);
            return;
        end
        exp = sent_q.pop_front();
        lo  = model_dec(rx[15:8]);
        hi  = model_dec(rx[7:0]);
        chk("rx_clean", exp, {hi, lo}, {2'b00, exp[7:4], 2'b00, exp[3:0]});
        pl = int'(exp) % 8;
        ph = (int'(exp) + 3) % 8;
        lo = model_dec(rx[15:8] ^ (8'h01 << pl));
        hi = model_dec(rx[7:0] ^ (8'h01 << ph));
        chk("rx_flip1", exp, {hi, lo}, {2'b01, exp[7:4], 2'b01, exp[3:0]});
        lo = model_dec(rx[15:8] ^ (8'h01 << pl) ^ (8'h01 << ((pl + 1) % 8)));
        hi = model_dec(rx[7:0] ^ (8'h01 << ph) ^ (8'h01 << ((ph + 1) % 8)));
        chk("rx_flip2_flags", exp, {hi[5:4], lo[5:4]}, 4'b1010);
    endtask

    initial begin
        logic [15:0] rx;
        int          rc;
        rx = '0;
        rc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rc = 0;
            end else if (tx_active_v[1]) begin
                rx = {rx[14:0], tx_bit_v[1]};
                rc++;
                if (rc == 16) begin
                    rc = 0;
                    check_byte(rx);
                end
            end
        end
    end

    // Sends one byte on dut0 and records the 16-bit stream over 72 cycles.
    task automatic send_cap(input logic [7:0] b, input int pulse_at,
                            output logic [15:0] stream, output int done_cnt,
                            output int done_k, output logic bad_hold,
                            output logic active_after);
        @(posedge clk); #1;
        in_valid_v[0] = 1'b1; in_data_v[0] = b;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0; in_data_v[0] = 8'h00;
        stream = '0; done_cnt = 0; done_k = -1; bad_hold = 1'b0; active_after = 1'b0;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            if (k < 64) begin
                if (k % 4 == 0) stream[15 - k / 4] = tx_bit_v[0];
                else if (tx_bit_v[0] !== stream[15 - k / 4]) bad_hold = 1'b1;
                if (!tx_active_v[0]) bad_hold = 1'b1;
            end
            if (tx_done_v[0]) begin done_cnt++; done_k = k; end
            if (k > 64 && tx_active_v[0]) active_after = 1'b1;
            if (k == pulse_at) begin
                in_valid_v[0] = 1'b1; in_data_v[0] = 8'hFF;
            end else if (pulse_at >= 0 && k == pulse_at + 1) begin
                in_valid_v[0] = 1'b0; in_data_v[0] = 8'h00;
            end
        end
    endtask

    initial begin
        logic [15:0] stream;
        int          done_cnt;
        int          done_k;
        logic        bad_hold;
        logic        act_after;
        logic [31:0] bits;
        logic [31:0] rdy_mask;
        logic        act_drop;
        int          first_done;
        int          last_done;
        int          n_done;

        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  0, in_ready_v[0],  1'b1);
        chk("rst_tx_active", 0, tx_active_v[0], 1'b0);
        chk("rst_tx_bit",    0, tx_bit_v[0],    1'b0);
        chk("rst_tx_done",   0, tx_done_v[0],   1'b0);
        chk("model_enc_1", 0, model_enc(4'h1), 8'h0F);
        chk("model_enc_E", 0, model_enc(4'hE), 8'hF0);
        chk("model_enc_4", 0, model_enc(4'h4), 8'h55);
        chk("model_enc_0", 0, model_enc(4'h0), 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        send_cap(8'hE1, -1, stream, done_cnt, done_k, bad_hold, act_after);
        chk("e1_stream",   0, stream,    16'h0FF0);
        chk("e1_hold",     0, bad_hold,  1'b0);
        chk("e1_done_cnt", 0, done_cnt,  1);
        chk("e1_done_at",  0, done_k,    64);
        chk("e1_idle",     0, act_after, 1'b0);
        chk("e1_ready",    0, in_ready_v[0], 1'b1);

        send_cap(8'h04, -1, stream, done_cnt, done_k, bad_hold, act_after);
        chk("b04_stream", 0, stream,   16'h5500);
        chk("b04_hold",   0, bad_hold, 1'b0);
        chk("b04_dec_lo", 0, model_dec(stream[15:8]), 6'h04);
        chk("b04_dec_hi", 0, model_dec(stream[7:0]),  6'h00);

        send_cap(8'hE1, 10, stream, done_cnt, done_k, bad_hold, act_after);
        chk("ign_stream",   0, stream,    16'h0FF0);
        chk("ign_done_cnt", 0, done_cnt,  1);
        chk("ign_no_next",  0, act_after, 1'b0);

        // Back-to-back on the one-cycle-per-bit instance.
        @(posedge clk); #1;
        in_valid_v[1] = 1'b1; in_data_v[1] = 8'hE1;
        @(posedge clk); #1;
        in_data_v[1] = 8'h04;
        bits = '0; rdy_mask = '0; act_drop = 1'b0;
        first_done = -1; last_done = -1; n_done = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (k < 32) begin
                bits[31 - k] = tx_bit_v[1];
                if (!tx_active_v[1]) act_drop = 1'b1;
                if (in_ready_v[1]) rdy_mask[k] = 1'b1;
            end
            if (tx_done_v[1]) begin
                n_done++;
                if (first_done < 0) first_done = k;
                last_done = k;
            end
            if (k == 16) in_valid_v[1] = 1'b0;
        end
        chk("b2b_bits",       1, bits,       32'h0FF0_5500);
        chk("b2b_active",     1, act_drop,   1'b0);
        chk("b2b_ready_mask", 1, rdy_mask,   32'h8000_8000);
        chk("b2b_done_cnt",   1, n_done,     2);
        chk("b2b_done_first", 1, first_done, 16);
        chk("b2b_done_last",  1, last_done,  32);

        // Reset during bit 5 of the low symbol of 0x04.
        @(posedge clk); #1;
        in_valid_v[0] = 1'b1; in_data_v[0] = 8'h04;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (22) @(negedge clk);
        chk("pre_rst_bit",    0, tx_bit_v[0],    1'b1);
        chk("pre_rst_active", 0, tx_active_v[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_active", 0, tx_active_v[0], 1'b0);
        chk("abort_bit",    0, tx_bit_v[0],    1'b0);
        chk("abort_ready",  0, in_ready_v[0],  1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_cap(8'hE1, -1, stream, done_cnt, done_k, bad_hold, act_after);
        chk("post_rst_stream", 0, stream,   16'h0FF0);
        chk("post_rst_done",   0, done_cnt, 1);

        // All 256 bytes streamed gaplessly; the loopback decoder checks each one.
        @(posedge clk); #1;
        in_valid_v[1] = 1'b1; in_data_v[1] = 8'h00;
        @(posedge clk);
        for (int b = 1; b < 256; b++) begin
            #1 in_data_v[1] = b[7:0];
            repeat (16) @(posedge clk);
        end
        #1 in_valid_v[1] = 1'b0;
        repeat (24) @(posedge clk);
        chk("all_bytes_received", 1, sent_q.size(), 0);
        chk("final_idle", 1, tx_active_v[1], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
